// File: rtl/uart_txq_pkg.sv
// uart_txq_pkg: shared drain FSM states and status register bit positions
package uart_txq_pkg;
    typedef enum logic {IDLE, WAIT} state_t;
    localparam int STATUS_EMPTY = 0;
    localparam int STATUS_FULL  = 1;
    localparam int STATUS_BUSY  = 2;
    localparam int STATUS_OVF   = 3;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: circular buffer with separately tracked occupancy and synchronous flush
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [W-1:0]           wr_data,
    input  logic                   rd_en,
    output logic [W-1:0]           rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_wr, do_rd;
    assign do_wr   = wr_en & ~full & ~flush;
    assign do_rd   = rd_en & ~empty & ~flush;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign rd_data = mem[rd_ptr];
    always_ff @(posedge clk)
        if (do_wr) mem[wr_ptr] <= wr_data;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end
endmodule

// File: rtl/uart_txq.sv
// uart_txq: byte queue between the CPU data register and the UART, drained via tx_ready handshake
module uart_txq
    import uart_txq_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int LOW_WM = 4,
    parameter int GUARD  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [7:0]             push_data,
    input  logic                   flush,
    input  logic                   clr_ovf,
    input  logic                   ie,
    input  logic                   tx_ready,
    output logic                   uart_wr,
    output logic [7:0]             uart_tx_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   ovf,
    output logic [15:0]            status,
    output logic                   irq
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int GW = $clog2(GUARD + 1);
    state_t        state;
    logic [GW-1:0] guard;
    logic [7:0]    head;
    logic          pop;
    sync_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .wr_en  (push),
        .wr_data(push_data),
        .rd_en  (pop),
        .rd_data(head),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );
    assign pop = (state == IDLE) & ~empty & tx_ready & ~flush;
    assign irq = ie & (count <= CW'(LOW_WM));
    always_comb begin
        status               = '0;
        status[STATUS_EMPTY] = empty;
        status[STATUS_FULL]  = full;
        status[STATUS_BUSY]  = state != IDLE;
        status[STATUS_OVF]   = ovf;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            uart_wr      <= 1'b0;
            uart_tx_data <= '0;
            guard        <= '0;
        end else begin
            uart_wr <= pop;
            if (pop) uart_tx_data <= head;
            if (state == IDLE) begin
                guard <= '0;
                if (pop) state <= WAIT;
            end else if (!tx_ready || guard == GW'(GUARD - 1)) begin
                state <= IDLE;
                guard <= '0;
            end else begin
                guard <= guard + 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf <= 1'b0;
        else if (push & ~flush & full) ovf <= 1'b1;
        else if (clr_ovf) ovf <= 1'b0;
    end
endmodule

// File: tb/tb_uart_txq.sv
// tb_uart_txq: scoreboard bench with a UART busy-time model and directed queue scenarios
module tb_uart_txq;
    logic        clk = 0, rst_n = 0, push = 0, flush = 0, clr_ovf = 0, ie = 0;
    logic [7:0]  push_data = 0;
    logic        tx_ready, uart_wr, empty, full, ovf, irq;
    logic [7:0]  uart_tx_data;
    logic [4:0]  count;
    logic [15:0] status;
    int          n_checks = 0, n_fail = 0;
    int          mode = 0;
    int          busy_cnt = 0;
    logic        prev_wr = 0;
    logic [7:0]  sb[$];

    uart_txq #(.DEPTH(16), .LOW_WM(4), .GUARD(4)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .push_data(push_data), .flush(flush),
        .clr_ovf(clr_ovf), .ie(ie), .tx_ready(tx_ready), .uart_wr(uart_wr),
        .uart_tx_data(uart_tx_data), .count(count), .empty(empty), .full(full),
        .ovf(ovf), .status(status), .irq(irq)
    );

    always #5 clk = ~clk;

    // mode 0: UART busy 10 cycles per byte, 1: tx_ready held low, 2: tx_ready stuck high
    always @(posedge clk)
        if (!rst_n) busy_cnt <= 0;
        else if (uart_wr) busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    assign tx_ready = (mode == 2) ? 1'b1 : (mode == 1) ? 1'b0 : (busy_cnt == 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && uart_wr) begin
            check("wr_not_consecutive", {31'd0, prev_wr}, 32'd0);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_wr: got %02h expected no write", uart_tx_data);
            end else begin
                check("tx_data", {24'd0, uart_tx_data}, {24'd0, sb.pop_front()});
            end
        end
        prev_wr = uart_wr;
    end

    task automatic do_push(input logic [7:0] d, input bit acc);
        push = 1;
        push_data = d;
        if (acc) sb.push_back(d);
        @(negedge clk);
        push = 0;
    endtask

    task automatic wait_drain(input int max);
        for (int i = 0; i < max; i++) begin
            if (sb.size() == 0 && empty && !uart_wr) break;
            @(negedge clk);
        end
        check("drained", sb.size(), 0);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int t0, t1;
        repeat (2) @(negedge clk);
        check("rst_uart_wr", {31'd0, uart_wr}, 0);
        check("rst_tx_data", {24'd0, uart_tx_data}, 0);
        check("rst_count", {27'd0, count}, 0);
        check("rst_empty", {31'd0, empty}, 1);
        check("rst_full", {31'd0, full}, 0);
        check("rst_ovf", {31'd0, ovf}, 0);
        check("rst_status", {16'd0, status}, 32'h0001);
        check("rst_irq_ie0", {31'd0, irq}, 0);
        ie = 1;
        #1 check("rst_irq_ie1", {31'd0, irq}, 1);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        do_push(8'h41, 1);
        check("lat_count1", {27'd0, count}, 1);
        check("lat_wr_early", {31'd0, uart_wr}, 0);
        @(negedge clk);
        check("lat_wr", {31'd0, uart_wr}, 1);
        check("lat_count0", {27'd0, count}, 0);
        @(negedge clk);
        check("lat_single_pulse", {31'd0, uart_wr}, 0);
        wait_drain(200);
        check("lat_empty", {31'd0, empty}, 1);

        mode = 1;
        for (int i = 0; i < 16; i++) do_push(8'(i), 1);
        check("fill_full", {31'd0, full}, 1);
        check("fill_count", {27'd0, count}, 16);
        check("fill_empty", {31'd0, empty}, 0);
        check("fill_irq", {31'd0, irq}, 0);
        check("fill_status", {16'd0, status}, 32'h0002);
        do_push(8'hFF, 0);
        check("ovf_count", {27'd0, count}, 16);
        check("ovf_set", {31'd0, ovf}, 1);
        check("ovf_status", {16'd0, status}, 32'h000A);
        clr_ovf = 1;
        do_push(8'hFE, 0);
        clr_ovf = 0;
        check("ovf_set_wins", {31'd0, ovf}, 1);
        check("ovf_count2", {27'd0, count}, 16);
        clr_ovf = 1;
        @(negedge clk);
        clr_ovf = 0;
        check("ovf_cleared", {31'd0, ovf}, 0);
        mode = 0;
        wait_drain(1000);
        check("full_drain_empty", {31'd0, empty}, 1);

        mode = 2;
        do_push(8'h51, 1);
        do_push(8'h52, 1);
        t0 = -1;
        t1 = -1;
        for (int i = 0; i < 50; i++) begin
            if (uart_wr) begin
                if (t0 < 0) t0 = i;
                else if (t1 < 0) t1 = i;
            end
            @(negedge clk);
        end
        check("guard_gap", t1 - t0, 5);
        wait_drain(100);
        mode = 0;

        for (int i = 0; i < 40; i++) begin
            do_push(8'(8'h60 + i), 1);
            repeat (9) @(negedge clk);
        end
        wait_drain(2000);
        check("stream_empty", {31'd0, empty}, 1);

        for (int i = 0; i < 5; i++) do_push(8'(8'hA0 + i), 1);
        check("wm_count4", {27'd0, count}, 4);
        check("wm_irq4", {31'd0, irq}, 1);
        do_push(8'hA5, 1);
        check("wm_count5", {27'd0, count}, 5);
        check("wm_irq5", {31'd0, irq}, 0);
        check("flush_queued", sb.size(), 5);
        flush = 1;
        @(negedge clk);
        flush = 0;
        sb.delete();
        check("flush_count", {27'd0, count}, 0);
        check("flush_empty", {31'd0, empty}, 1);
        check("flush_irq", {31'd0, irq}, 1);
        repeat (60) @(negedge clk);
        check("flush_inflight_done", {31'd0, tx_ready}, 1);
        check("final_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
